// File: rtl/udp_rx_strip.sv
// udp_rx_strip
//   Receive-side UDP header stripper on a fifo19 stream. Consumes padded
//   Ethernet/IPv4/UDP frames, checks ethertype, IP version/IHL, protocol,
//   destination IP and destination port against the settings registers.
//   The 2-byte pad plus the 42-byte header (22 lines) are removed and only
//   the UDP payload is forwarded. Frames that fail a check, end early, or
//   arrive while disabled are discarded whole and counted in `dropped`.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   clear             synchronous abort of the current frame, zeroes dropped
//   set_stb/addr/data settings bus: BASE+0 port, BASE+1 IPv4 addr, BASE+2 enable
//   datain            {occ, eof, sof, data[15:0]}, src_rdy_i / dst_rdy_o
//   dataout           payload in the same format, src_rdy_o / dst_rdy_i
//   dropped           number of discarded frames (wraps)
//
// Handshake: a line moves across a port only on a rising edge where that
// port's src_rdy and dst_rdy are both 1; nothing else changes any state.
module udp_rx_strip #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [18:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [18:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [15:0] dropped
);

  localparam logic [7:0] ADDR_PORT = BASE;
  localparam logic [7:0] ADDR_IP   = BASE + 8'd1;
  localparam logic [7:0] ADDR_EN   = BASE + 8'd2;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;         // index of the next expected header line; 0 = waiting for SOF
  logic        first_flag;  // marks the first payload transfer as SOF
  logic [15:0] port;
  logic [31:0] ip;
  logic        enable;

  logic        sof;
  logic        eof;
  logic [15:0] word;
  logic [4:0]  line_idx;
  logic        garbage;
  logic        hdr_fail;

  assign word = datain[15:0];
  assign sof  = datain[16];
  assign eof  = datain[17];

  // SOF always restarts the header at line 0, even mid-header.
  assign line_idx = sof ? 5'd0 : cnt;
  // Without SOF and with the counter at 0 we are between frames.
  assign garbage  = !sof && (cnt == 5'd0);

  // Settings registers; clear leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      port   <= 16'd0;
      ip     <= 32'd0;
      enable <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == ADDR_PORT) port   <= set_data[15:0];
      if (set_addr == ADDR_IP)   ip     <= set_data;
      if (set_addr == ADDR_EN)   enable <= set_data[0];
    end
  end

  // Per-line header check for the line currently on datain.
  always_comb begin
    hdr_fail = !enable;
    case (line_idx)
      5'd7:    if (word != 16'h0800)     hdr_fail = 1'b1;
      5'd8:    if (word != 16'h4500)     hdr_fail = 1'b1;
      5'd12:   if (word[7:0] != 8'd17)   hdr_fail = 1'b1;
      5'd16:   if (word != ip[31:16])    hdr_fail = 1'b1;
      5'd17:   if (word != ip[15:0])     hdr_fail = 1'b1;
      5'd19:   if (word != port)         hdr_fail = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= HDR;
      cnt        <= 5'd0;
      first_flag <= 1'b0;
      dropped    <= 16'd0;
    end else begin
      case (state)
        HDR: begin
          if (src_rdy_i && !garbage) begin
            if (hdr_fail) begin
              cnt <= 5'd0;
              if (eof) dropped <= dropped + 16'd1;
              else     state   <= DROP;
            end else if (eof) begin
              // Runt, including a header-only frame ending on line 21.
              dropped <= dropped + 16'd1;
              cnt     <= 5'd0;
            end else if (line_idx == 5'd21) begin
              state      <= PAYLOAD;
              first_flag <= 1'b1;
              cnt        <= 5'd0;
            end else begin
              cnt <= line_idx + 5'd1;
            end
          end
        end
        PAYLOAD: begin
          if (src_rdy_i && dst_rdy_i) begin
            first_flag <= 1'b0;
            if (eof) state <= HDR;
          end
        end
        DROP: begin
          if (src_rdy_i && eof) begin
            dropped <= dropped + 16'd1;
            state   <= HDR;
          end
        end
        default: begin
          state <= HDR;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

  // Zero-latency pass-through in PAYLOAD; the SOF bit is regenerated so it
  // marks the first payload line rather than the frame's pad line.
  always_comb begin
    if (state == PAYLOAD) begin
      dst_rdy_o = dst_rdy_i;
      src_rdy_o = src_rdy_i;
      dataout   = {datain[18:17], first_flag, datain[15:0]};
    end else begin
      dst_rdy_o = 1'b1;
      src_rdy_o = 1'b0;
      dataout   = 19'd0;
    end
  end

endmodule

// File: tb/tb_udp_rx_strip.sv
module tb_udp_rx_strip;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [18:0] datain;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic [18:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i;
  logic [15:0] dropped;

  udp_rx_strip #(.BASE(8'd0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .datain(datain), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .dataout(dataout), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .dropped(dropped)
  );

  // ---------------- scoreboard state ----------------
  logic [18:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_dropped = 16'd0;

  // Reference copy of the settings as software believes them to be.
  logic [15:0] m_port = 16'd0;
  logic [31:0] m_ip   = 32'd0;
  logic        m_en   = 1'b0;

  logic [15:0] frm[$];
  logic        frm_occ;
  bit          gaps_on = 0;
  int          bp_mode = 0;  // 0 always ready, 1 random, 2 pattern 1,0,0,1
  int          pat_i   = 0;

  localparam logic [31:0] MY_IP   = 32'hC0A8_0A02;  // 192.168.10.2
  localparam logic [15:0] MY_PORT = 16'd49153;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- downstream ready generator ----------------
  always begin
    @(posedge clk);
    #1;
    case (bp_mode)
      1: dst_rdy_i = 1'($urandom_range(0, 1));
      2: begin
        dst_rdy_i = (pat_i == 1 || pat_i == 2) ? 1'b0 : 1'b1;
        pat_i = (pat_i + 1) % 4;
      end
      default: dst_rdy_i = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && src_rdy_o) begin
      check("dst_rdy_follow", {31'd0, dst_rdy_o}, {31'd0, dst_rdy_i});
      if (dst_rdy_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {13'd0, dataout}, 32'hFFFF_FFFF);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          check("payload", {13'd0, dataout}, {13'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    idle(1);
    set_stb  = 1'b0;
  endtask

  task automatic configure(input logic [15:0] p, input logic [31:0] a, input logic en);
    write_reg(8'd0, {16'd0, p});
    write_reg(8'd1, a);
    write_reg(8'd2, {31'd0, en});
    m_port = p;
    m_ip   = a;
    m_en   = en;
    idle(1);
  endtask

  task automatic build_frame(input logic [15:0] p, input logic [31:0] a,
                             input logic [7:0] proto, input int npay, input logic occ);
    frm.delete();
    frm.push_back(16'h0000);
    for (int i = 0; i < 6; i++) frm.push_back(16'($urandom));
    frm.push_back(16'h0800);
    frm.push_back(16'h4500);
    frm.push_back(16'($urandom));          // total length
    frm.push_back(16'($urandom));          // identification
    frm.push_back(16'h4000);               // flags / fragment
    frm.push_back({8'd64, proto});
    frm.push_back(16'($urandom));          // header checksum
    frm.push_back(16'($urandom));          // source IP
    frm.push_back(16'($urandom));
    frm.push_back(a[31:16]);
    frm.push_back(a[15:0]);
    frm.push_back(16'($urandom));          // source port
    frm.push_back(p);
    frm.push_back(16'($urandom));          // UDP length
    frm.push_back(16'($urandom));          // UDP checksum
    for (int i = 0; i < npay; i++) frm.push_back(16'($urandom));
    frm_occ = occ;
  endtask

  // Reference model: whole-frame decision from the header layout.
  task automatic model_frame();
    int n;
    bit ok;
    n  = frm.size();
    ok = m_en && (n > 22);
    if (ok) begin
      ok = (frm[7] == 16'h0800) && (frm[8] == 16'h4500) && (frm[12][7:0] == 8'd17) &&
           (frm[16] == m_ip[31:16]) && (frm[17] == m_ip[15:0]) && (frm[19] == m_port);
    end
    if (!ok) begin
      exp_dropped = exp_dropped + 16'd1;
    end else begin
      for (int i = 22; i < n; i++) begin
        bit last;
        last = (i == n - 1);
        exp_q.push_back({frm_occ && last, last, i == 22, frm[i]});
      end
    end
  endtask

  // Sends the first `limit` lines of frm; EOF goes on the frame's last line.
  task automatic send_frame(input int limit);
    int n;
    n = (limit < frm.size()) ? limit : frm.size();
    for (int i = 0; i < n; i++) begin
      int t;
      bit last;
      if (gaps_on && $urandom_range(0, 3) == 0) begin
        src_rdy_i = 1'b0;
        datain    = 19'($urandom);
        idle($urandom_range(1, 3));
      end
      last      = (i == frm.size() - 1);
      datain    = {frm_occ && last, last, i == 0, frm[i]};
      src_rdy_i = 1'b1;
      t = 0;
      @(negedge clk);
      while (!dst_rdy_o && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) check("input_stall_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
    end
    src_rdy_i = 1'b0;
    datain    = 19'd0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      idle(1);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
    check("dropped", {16'd0, dropped}, {16'd0, exp_dropped});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; clear = 1'b0;
    set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    datain = 19'd0; src_rdy_i = 1'b0; dst_rdy_i = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_src_rdy", {31'd0, src_rdy_o}, 32'd0);
    check("rst_dst_rdy", {31'd0, dst_rdy_o}, 32'd1);
    check("rst_dataout", {13'd0, dataout}, 32'd0);
    check("rst_dropped", {16'd0, dropped}, 32'd0);
    idle(1);

    // Happy path with fixed payload words.
    configure(MY_PORT, MY_IP, 1'b1);
    build_frame(MY_PORT, MY_IP, 8'd17, 4, 1'b1);
    frm[22] = 16'hA1A1; frm[23] = 16'hB2B2; frm[24] = 16'hC3C3; frm[25] = 16'hD4D4;
    model_frame(); send_frame(100); drain();

    // Wrong port, then a good frame.
    build_frame(16'd49154, MY_IP, 8'd17, 10, 1'b0);
    model_frame(); send_frame(100); drain();
    build_frame(MY_PORT, MY_IP, 8'd17, 5, 1'b1);
    model_frame(); send_frame(100); drain();

    // Runt ending on line 15, and a header-only frame.
    build_frame(MY_PORT, MY_IP, 8'd17, 0, 1'b0);
    while (frm.size() > 16) void'(frm.pop_back());
    model_frame(); send_frame(100); drain();
    build_frame(MY_PORT, MY_IP, 8'd17, 0, 1'b1);
    model_frame(); send_frame(100); drain();

    // Disabled.
    configure(MY_PORT, MY_IP, 1'b0);
    build_frame(MY_PORT, MY_IP, 8'd17, 3, 1'b0);
    model_frame(); send_frame(100); drain();
    configure(MY_PORT, MY_IP, 1'b1);

    // Idle garbage lines (no SOF) before a frame are ignored.
    for (int i = 0; i < 4; i++) begin
      datain    = {2'($urandom_range(0, 3)), 1'b0, 16'($urandom)};
      src_rdy_i = 1'b1;
      idle(1);
    end
    src_rdy_i = 1'b0;
    build_frame(MY_PORT, MY_IP, 8'd17, 2, 1'b0);
    model_frame(); send_frame(100); drain();

    // Backpressure pattern 1,0,0,1 on a 6-line payload.
    bp_mode = 2;
    build_frame(MY_PORT, MY_IP, 8'd17, 6, 1'b1);
    model_frame(); send_frame(100); drain();
    bp_mode = 0;

    // Randomized mix with input gaps and random backpressure.
    gaps_on = 1;
    for (int k = 0; k < 30; k++) begin
      int kind;
      bp_mode = $urandom_range(0, 1);
      kind = $urandom_range(0, 8);
      build_frame(MY_PORT, MY_IP, 8'd17, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      case (kind)
        2: frm[19] = frm[19] ^ 16'(1 << $urandom_range(0, 15));
        3: frm[17] = frm[17] ^ 16'(1 << $urandom_range(0, 15));
        4: frm[12] = {frm[12][15:8], 8'd6};
        5: begin
          int len;
          len = $urandom_range(1, 22);
          while (frm.size() > len) void'(frm.pop_back());
        end
        6: frm[7] = 16'h86DD;
        7: frm[8] = 16'h4600;
        default: ;
      endcase
      model_frame(); send_frame(100); drain();
    end
    gaps_on = 0;
    bp_mode = 0;

    // Clear mid-header: dropped zeroes, settings survive.
    build_frame(MY_PORT, MY_IP, 8'd17, 4, 1'b0);
    send_frame(10);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    exp_dropped = 16'd0;
    @(negedge clk);
    check("clear_dropped", {16'd0, dropped}, 32'd0);
    idle(1);
    build_frame(MY_PORT, MY_IP, 8'd17, 4, 1'b1);
    model_frame(); send_frame(100); drain();

    // Make dropped non-zero, then reset in the middle of a payload.
    build_frame(MY_PORT, 32'h0A00_0001, 8'd17, 2, 1'b0);
    model_frame(); send_frame(100); drain();
    build_frame(MY_PORT, MY_IP, 8'd17, 8, 1'b0);
    for (int i = 22; i < 25; i++) exp_q.push_back({2'b00, i == 22, frm[i]});
    send_frame(25);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_src_rdy", {31'd0, src_rdy_o}, 32'd0);
    check("mid_rst_dst_rdy", {31'd0, dst_rdy_o}, 32'd1);
    check("mid_rst_dropped", {16'd0, dropped}, 32'd0);
    check("mid_rst_flushed", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_port = 16'd0; m_ip = 32'd0; m_en = 1'b0;
    exp_dropped = 16'd0;
    idle(1);
    build_frame(MY_PORT, MY_IP, 8'd17, 3, 1'b0);
    model_frame(); send_frame(100); drain();
    configure(MY_PORT, MY_IP, 1'b1);
    build_frame(MY_PORT, MY_IP, 8'd17, 3, 1'b1);
    model_frame(); send_frame(100); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
